fdtd_ez_ctrl: RTL

FDTD_EZ_CTRL -- requirements
Module: fdtd_ez_ctrl

---
 rtl/fdtd_pkg.sv | 13 +
 rtl/fdtd_ez_ctrl_if.sv | 43 ++++
 rtl/fdtd_valid_pipe.sv | 46 ++++
 rtl/fdtd_ez_ctrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/fdtd_pkg.sv
// rtl/fdtd_pkg.sv - shared sweep-state type and latency default for the Ez update controller
package fdtd_pkg;

  localparam int FDTD_LAT_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fdtd_state_e;

endpackage

// File: rtl/fdtd_ez_ctrl_if.sv
// rtl/fdtd_ez_ctrl_if.sv - host/memory bus bundle of fdtd_ez_ctrl (src_* present with FDTD_EZ_SRC_EN)
interface fdtd_ez_ctrl_if #(
  parameter int FDTD_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH      = 10
) (
  input logic CLK
);

  logic                       start_i;
  logic [ADDR_WIDTH-1:0]      n_cells_i;
  logic                       hold_i;
  logic [FDTD_DATA_WIDTH-1:0] Ez_n_i;
`ifdef FDTD_EZ_SRC_EN
  logic [ADDR_WIDTH-1:0]      src_idx_i;
  logic [FDTD_DATA_WIDTH-1:0] src_val_i;
`endif
  logic                       clken_o;
  logic                       rd_en_o;
  logic [ADDR_WIDTH-1:0]      rd_addr_o;
  logic                       wr_en_o;
  logic [ADDR_WIDTH-1:0]      wr_addr_o;
  logic [FDTD_DATA_WIDTH-1:0] wr_data_o;
  logic                       busy_o;
  logic                       done_o;

  // master is the controller side, slave the host/memory/datapath side
  modport master (
    input  CLK, start_i, n_cells_i, hold_i, Ez_n_i,
`ifdef FDTD_EZ_SRC_EN
    input  src_idx_i, src_val_i,
`endif
    output clken_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o
  );

  modport slave (
    input  CLK, clken_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o,
`ifdef FDTD_EZ_SRC_EN
    output src_idx_i, src_val_i,
`endif
    output start_i, n_cells_i, hold_i, Ez_n_i
  );

endinterface

// File: rtl/fdtd_valid_pipe.sv
// rtl/fdtd_valid_pipe.sv - enable-gated valid+data delay line tracking in-flight reads
module fdtd_valid_pipe #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_pending
);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_data[i]  <= '0;
      end
    end else if (i_en) begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  // pending: something other than the output stage still in flight
  always_comb begin
    o_pending = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      o_pending = o_pending | r_valid[i];
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/fdtd_ez_ctrl.sv
// rtl/fdtd_ez_ctrl.sv - Ez sweep controller: streams reads, writes back updated cells; FDTD_EZ_SRC_EN adds a hard source
module fdtd_ez_ctrl
  import fdtd_pkg::*;
#(
  parameter int FDTD_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int LAT             = FDTD_LAT_DEFAULT
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       start_i,
  input  logic [ADDR_WIDTH-1:0]      n_cells_i,
  input  logic                       hold_i,
  input  logic [FDTD_DATA_WIDTH-1:0] Ez_n_i,
`ifdef FDTD_EZ_SRC_EN
  input  logic [ADDR_WIDTH-1:0]      src_idx_i,
  input  logic [FDTD_DATA_WIDTH-1:0] src_val_i,
`endif
  output logic                       clken_o,
  output logic                       rd_en_o,
  output logic [ADDR_WIDTH-1:0]      rd_addr_o,
  output logic                       wr_en_o,
  output logic [ADDR_WIDTH-1:0]      wr_addr_o,
  output logic [FDTD_DATA_WIDTH-1:0] wr_data_o,
  output logic                       busy_o,
  output logic                       done_o
);

  fdtd_state_e               r_state;
  logic [ADDR_WIDTH-1:0]     r_n;
  logic [ADDR_WIDTH-1:0]     r_rd_cnt;

  logic                       w_active;
  logic                       w_clken;
  logic                       w_rd_en;
  logic                       w_wr_en;
  logic                       w_trk_valid;
  logic                       w_pending;
  logic [ADDR_WIDTH-1:0]      w_trk_addr;
  logic [FDTD_DATA_WIDTH-1:0] w_wr_data;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_n      <= '0;
      r_rd_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_n      <= n_cells_i;
            r_rd_cnt <= '0;
            r_state  <= (n_cells_i >= ADDR_WIDTH'(2)) ? ST_FILL : ST_DONE;
          end
        end
        ST_FILL: begin
          if (!hold_i) begin
            if (r_rd_cnt == r_n - ADDR_WIDTH'(1)) begin
              r_state <= ST_DRAIN;
            end else begin
              r_rd_cnt <= r_rd_cnt + ADDR_WIDTH'(1);
            end
          end
        end
        // leave once the entry retiring this cycle is the last one in flight
        ST_DRAIN: begin
          if (!hold_i && !w_pending) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_active = (r_state == ST_FILL) || (r_state == ST_DRAIN);
  assign w_clken  = w_active && !hold_i;
  assign w_rd_en  = (r_state == ST_FILL) && !hold_i;

  fdtd_valid_pipe #(
    .DEPTH (LAT),
    .WIDTH (ADDR_WIDTH)
  ) u_trk (
    .clk       (CLK),
    .rst       (RST),
    .i_en      (w_clken),
    .i_valid   (w_rd_en),
    .i_data    (r_rd_cnt),
    .o_valid   (w_trk_valid),
    .o_data    (w_trk_addr),
    .o_pending (w_pending)
  );

  // cell 0 is the PEC boundary and is never written back
  assign w_wr_en = w_clken && w_trk_valid && (w_trk_addr != '0);

`ifdef FDTD_EZ_SRC_EN
  assign w_wr_data = (w_trk_addr == src_idx_i) ? src_val_i : Ez_n_i;
`else
  assign w_wr_data = Ez_n_i;
`endif

  assign clken_o   = w_clken;
  assign rd_en_o   = w_rd_en;
  assign rd_addr_o = w_rd_en ? r_rd_cnt : '0;
  assign wr_en_o   = w_wr_en;
  assign wr_addr_o = w_wr_en ? w_trk_addr : '0;
  assign wr_data_o = w_wr_en ? w_wr_data : '0;
  assign busy_o    = w_active;
  assign done_o    = (r_state == ST_DONE);

endmodule
